// File: rtl/pipe_datapath_fwd.sv
// Four-stage (ID/EX/MEM/WB) MIPS-subset datapath with internal register file and data memory,
// EX/MEM and MEM/WB operand forwarding, and load-use (or full RAW when forwarding is off) stalling.
module pipe_datapath_fwd #(
    parameter int DATA_W     = 32,
    parameter int NREG       = 32,
    parameter int DMEM_DEPTH = 256,
    parameter int FWD_EN     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr,
    input  logic              instr_valid,
    input  logic [1:0]        WBID,
    input  logic [2:0]        MEID,
    input  logic [3:0]        EXID,
    output logic              stall,
    output logic              zero_reg,
    output logic              branch_me,
    output logic              wb_valid,
    output logic [4:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data
);
    localparam int RW = $clog2(NREG);
    localparam int AW = $clog2(DMEM_DEPTH);

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} aluop_t;

    logic [DATA_W-1:0] regFile [NREG];
    logic [DATA_W-1:0] dmem [DMEM_DEPTH];

    logic [RW-1:0]     idRs, idRt, idRd;
    logic [DATA_W-1:0] idA, idB, idImm;

    logic              exValid;
    logic [1:0]        exWb;
    logic [2:0]        exMe;
    logic [3:0]        exCtl;
    logic [RW-1:0]     exRs, exRt, exRd, exDest;
    logic [5:0]        exFunct;
    logic [DATA_W-1:0] exA, exB, exImm, opA, opB, aluB, aluRes;
    aluop_t            aluSel;

    logic              memValid;
    logic [1:0]        memWb;
    logic [2:0]        memMe;
    logic [DATA_W-1:0] memAlu, memStore, memRdata;
    logic [RW-1:0]     memDest;
    logic [AW-1:0]     memAddr;

    logic              wbWrite, wbMemToReg;
    logic [DATA_W-1:0] wbAlu, wbMem, wbData;
    logic [RW-1:0]     wbDest;

    logic memHitA, memHitB, wbHitA, wbHitB, hazard;
    logic unusedOpcode;

    assign unusedOpcode = ^instr[31:26];

    assign idRs  = instr[21 +: RW];
    assign idRt  = instr[16 +: RW];
    assign idRd  = instr[11 +: RW];
    assign idImm = {{(DATA_W-16){instr[15]}}, instr[15:0]};

    // Register read with write-first bypass so the WB stage never needs a forward path into ID.
    always_comb begin
        idA = regFile[idRs];
        idB = regFile[idRt];
        if (wbWrite && wbDest == idRs) idA = wbData;
        if (wbWrite && wbDest == idRt) idB = wbData;
        if (idRs == '0) idA = '0;
        if (idRt == '0) idB = '0;
    end

    assign exDest  = exCtl[3] ? exRd : exRt;
    assign memHitA = memValid && memWb[1] && memDest != '0 && memDest == exRs;
    assign memHitB = memValid && memWb[1] && memDest != '0 && memDest == exRt;
    assign wbHitA  = wbWrite && wbDest == exRs;
    assign wbHitB  = wbWrite && wbDest == exRt;

    always_comb begin
        opA = exA;
        opB = exB;
        if (FWD_EN != 0) begin
            if (memHitA)     opA = memAlu;
            else if (wbHitA) opA = wbData;
            if (memHitB)     opB = memAlu;
            else if (wbHitB) opB = wbData;
        end
    end

    assign aluB = exCtl[0] ? exImm : opB;

    always_comb begin
        aluSel = ALU_ADD;
        case (exCtl[2:1])
            2'b00: aluSel = ALU_ADD;
            2'b01: aluSel = ALU_SUB;
            2'b11: aluSel = ALU_SLT;
            default: begin
                case (exFunct)
                    6'b100010: aluSel = ALU_SUB;
                    6'b100100: aluSel = ALU_AND;
                    6'b100101: aluSel = ALU_OR;
                    6'b101010: aluSel = ALU_SLT;
                    default:   aluSel = ALU_ADD;
                endcase
            end
        endcase
    end

    always_comb begin
        aluRes = opA + aluB;
        case (aluSel)
            ALU_SUB: aluRes = opA - aluB;
            ALU_AND: aluRes = opA & aluB;
            ALU_OR:  aluRes = opA | aluB;
            ALU_SLT: aluRes = {{(DATA_W-1){1'b0}}, ($signed(opA) < $signed(aluB))};
            default: aluRes = opA + aluB;
        endcase
    end

    // Without forwarding every producer still in EX or MEM blocks the consumer.
    always_comb begin
        hazard = 1'b0;
        if (FWD_EN != 0) begin
            hazard = exValid && exMe[1] && exDest != '0 && (exDest == idRs || exDest == idRt);
        end else begin
            hazard = (exValid && exWb[1] && exDest != '0 && (exDest == idRs || exDest == idRt))
                  || (memValid && memWb[1] && memDest != '0 && (memDest == idRs || memDest == idRt));
        end
    end

    assign memAddr  = memAlu[AW+1:2];
    assign memRdata = dmem[memAddr];
    assign wbData   = wbMemToReg ? wbMem : wbAlu;

    assign stall     = hazard;
    assign zero_reg  = memValid && (memAlu == '0);
    assign branch_me = memMe[2];
    assign wb_valid  = wbWrite;
    assign wb_addr   = wbWrite ? 5'(wbDest) : 5'd0;
    assign wb_data   = wbWrite ? wbData : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            exValid <= 1'b0; exWb <= '0; exMe <= '0; exCtl <= '0;
            exRs <= '0; exRt <= '0; exRd <= '0; exFunct <= '0;
            exA <= '0; exB <= '0; exImm <= '0;
            memValid <= 1'b0; memWb <= '0; memMe <= '0;
            memAlu <= '0; memStore <= '0; memDest <= '0;
            wbWrite <= 1'b0; wbMemToReg <= 1'b0; wbAlu <= '0; wbMem <= '0; wbDest <= '0;
        end else begin
            if (instr_valid && !hazard) begin
                exValid <= 1'b1; exWb <= WBID; exMe <= MEID; exCtl <= EXID;
            end else begin
                exValid <= 1'b0; exWb <= '0; exMe <= '0; exCtl <= '0;
            end
            exRs <= idRs; exRt <= idRt; exRd <= idRd; exFunct <= instr[5:0];
            exA <= idA; exB <= idB; exImm <= idImm;
            memValid <= exValid; memWb <= exWb; memMe <= exMe;
            memAlu <= aluRes; memStore <= opB; memDest <= exDest;
            wbWrite    <= memValid && memWb[1] && memDest != '0;
            wbMemToReg <= memWb[0];
            wbAlu <= memAlu; wbMem <= memRdata; wbDest <= memDest;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regFile[i] <= '0;
        end else if (wbWrite) begin
            regFile[wbDest] <= wbData;
        end
    end

    // Memory contents survive reset; only the in-flight store is suppressed.
    always_ff @(posedge clk) begin
        if (!rst && memValid && memMe[0]) dmem[memAddr] <= memStore;
    end
endmodule

// File: tb/tb_pipe_datapath_fwd.sv
// Bench for pipe_datapath_fwd: directed scenarios plus random programs, checked against an
// architectural (in-order, one-instruction-at-a-time) model with a per-cycle timeline of slots.
module tb_pipe_datapath_fwd;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        instr_valid;
    logic [1:0]  WBID;
    logic [2:0]  MEID;
    logic [3:0]  EXID;

    logic stall1, zero1, br1, wbv1, stall0, zero0, br0, wbv0;
    logic [4:0]  wba1, wba0;
    logic [31:0] wbd1, wbd0;

    bit mode;
    logic oStall, oZero, oBr, oWbv;
    logic [4:0]  oWba;
    logic [31:0] oWbd;

    always #5 clk = ~clk;

    pipe_datapath_fwd #(.DATA_W(32), .NREG(32), .DMEM_DEPTH(256), .FWD_EN(1)) dutFwd (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .WBID(WBID), .MEID(MEID), .EXID(EXID),
        .stall(stall1), .zero_reg(zero1), .branch_me(br1),
        .wb_valid(wbv1), .wb_addr(wba1), .wb_data(wbd1));

    pipe_datapath_fwd #(.DATA_W(32), .NREG(32), .DMEM_DEPTH(256), .FWD_EN(0)) dutNoFwd (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .WBID(WBID), .MEID(MEID), .EXID(EXID),
        .stall(stall0), .zero_reg(zero0), .branch_me(br0),
        .wb_valid(wbv0), .wb_addr(wba0), .wb_data(wbd0));

    assign oStall = mode ? stall1 : stall0;
    assign oZero  = mode ? zero1  : zero0;
    assign oBr    = mode ? br1    : br0;
    assign oWbv   = mode ? wbv1   : wbv0;
    assign oWba   = mode ? wba1   : wba0;
    assign oWbd   = mode ? wbd1   : wbd0;

    localparam logic [1:0] WB_NONE = 2'b00, WB_ALU = 2'b10, WB_MEM = 2'b11;
    localparam logic [2:0] ME_NONE = 3'b000, ME_BR = 3'b100, ME_RD = 3'b010, ME_WR = 3'b001;
    localparam logic [3:0] EX_R = 4'b1100, EX_IMM = 4'b0001, EX_SUB = 4'b0010, EX_SLTI = 4'b0111;

    // One slot per cycle: what the instruction accepted in that cycle is expected to do.
    typedef struct packed {
        logic        v;
        logic        load;
        logic        regw;
        logic [4:0]  dest;
        logic [31:0] data;
        logic        branch;
        logic        zero;
        logic        store;
        logic [7:0]  widx;
        logic [31:0] old;
    } slot_t;

    slot_t       hist [0:8191];
    logic [31:0] mreg [32];
    logic [31:0] mmem [256];
    int cyc = 0, lowBound = 0;
    int checks = 0, failures = 0, obsStalls = 0;

    function automatic slot_t getSlot(int c);
        if (c < lowBound || c < 0) return '0;
        return hist[c];
    endfunction

    function automatic logic [31:0] aluModel(logic [1:0] op, logic [5:0] f, logic [31:0] a, logic [31:0] b);
        if (op == 2'b00) return a + b;
        if (op == 2'b01) return a - b;
        if (op == 2'b11) return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        if (f == 6'h22) return a - b;
        if (f == 6'h24) return a & b;
        if (f == 6'h25) return a | b;
        if (f == 6'h2a) return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        return a + b;
    endfunction

    function automatic logic dependsOn(slot_t s, logic [31:0] ins);
        return s.v && s.dest != 5'd0 && (s.dest == ins[25:21] || s.dest == ins[20:16]);
    endfunction

    function automatic logic expStall(logic [31:0] ins);
        slot_t s1, s2;
        s1 = getSlot(cyc - 1);
        s2 = getSlot(cyc - 2);
        if (mode) return dependsOn(s1, ins) && s1.load;
        return (dependsOn(s1, ins) && s1.regw) || (dependsOn(s2, ins) && s2.regw);
    endfunction

    function automatic logic [31:0] rtype(int rs, int rt, int rd, logic [5:0] f);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, f};
    endfunction

    function automatic logic [31:0] itype(logic [5:0] op, int rs, int rt, logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [1:0] wb,
                                 input logic [2:0] me, input logic [3:0] ex, output logic accepted);
        slot_t s2, s3, sn;
        logic es, wbExp;
        logic [31:0] a, b, res, ldv;
        if (cyc >= 8100) begin
            $display("[TB] FAIL cycle_budget cycle=%0d limit=8100", cyc);
            $fatal(1, "[TB] cycle budget exhausted");
        end
        instr = ins; instr_valid = v; WBID = wb; MEID = me; EXID = ex;
        @(negedge clk);
        s2 = getSlot(cyc - 2);
        s3 = getSlot(cyc - 3);
        es = expStall(ins);
        wbExp = s3.v && s3.regw && s3.dest != 5'd0;
        checkOutput("stall", 32'(oStall), 32'(es));
        checkOutput("wb_valid", 32'(oWbv), 32'(wbExp));
        if (wbExp) begin
            checkOutput("wb_addr", 32'(oWba), 32'(s3.dest));
            checkOutput("wb_data", oWbd, s3.data);
        end
        checkOutput("branch_me", 32'(oBr), 32'(s2.v && s2.branch));
        if (s2.v) checkOutput("zero_reg", 32'(oZero), 32'(s2.zero));
        if (cyc == lowBound) begin
            checkOutput("rst_wb_addr", 32'(oWba), 32'd0);
            checkOutput("rst_wb_data", oWbd, 32'd0);
            checkOutput("rst_zero_reg", 32'(oZero), 32'd0);
        end
        if (oStall) obsStalls++;
        accepted = v && !es;
        sn = '0;
        if (accepted) begin
            a   = mreg[ins[25:21]];
            b   = mreg[ins[20:16]];
            res = aluModel(ex[2:1], ins[5:0], a, ex[0] ? {{16{ins[15]}}, ins[15:0]} : b);
            sn.v = 1'b1; sn.load = me[1]; sn.regw = wb[1]; sn.store = me[0];
            sn.branch = me[2]; sn.zero = (res == 32'd0);
            sn.dest = ex[3] ? ins[15:11] : ins[20:16];
            sn.widx = res[9:2];
            ldv = mmem[sn.widx];
            if (me[0]) begin
                sn.old = mmem[sn.widx];
                mmem[sn.widx] = b;
            end
            sn.data = wb[0] ? ldv : res;
            if (wb[1] && sn.dest != 5'd0) mreg[sn.dest] = sn.data;
        end
        hist[cyc] = sn;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic issue(logic [31:0] ins, logic [1:0] wb, logic [2:0] me, logic [3:0] ex);
        logic acc;
        int n = 0;
        do begin
            applyStimulus(1'b1, ins, wb, me, ex, acc);
            n++;
        end while (!acc && n < 8);
        if (!acc) checkOutput("issue_timeout", 32'(acc), 32'd1);
    endtask

    task automatic idle(int n);
        logic acc;
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'd0, WB_NONE, ME_NONE, 4'd0, acc);
    endtask

    // In-flight stores (EX and MEM at the reset edge) never reach memory, so undo them in the model.
    task automatic doReset();
        slot_t s;
        rst = 1'b1; instr_valid = 1'b0; instr = '0; WBID = '0; MEID = '0; EXID = '0;
        @(negedge clk);
        @(posedge clk);
        #1;
        s = getSlot(cyc - 1);
        if (s.v && s.store) mmem[s.widx] = s.old;
        s = getSlot(cyc - 2);
        if (s.v && s.store) mmem[s.widx] = s.old;
        for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
        cyc++;
        lowBound = cyc;
        rst = 1'b0;
    endtask

    task automatic prelude();
        for (int k = 0; k < 8; k++) issue(itype(6'h2b, 0, 0, 16'(4 * k)), WB_NONE, ME_WR, EX_IMM);
        idle(3);
    endtask

    task automatic randomProgram(int n);
        logic [5:0] ftab [6];
        logic [5:0] f;
        int kind, rs, rt, rd;
        ftab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00};
        for (int i = 0; i < n; i++) begin
            rs = $urandom_range(0, 7); rt = $urandom_range(0, 7); rd = $urandom_range(0, 7);
            kind = $urandom_range(0, 6);
            case (kind)
                0: begin
                    f = ftab[$urandom_range(0, 5)];
                    if (f == 6'h00) f = 6'($urandom);
                    issue(rtype(rs, rt, rd, f), WB_ALU, ME_NONE, EX_R);
                end
                1: issue(itype(6'h08, rs, rt, 16'($urandom)), WB_ALU, ME_NONE, EX_IMM);
                2: issue(itype(6'h0a, rs, rt, 16'($urandom_range(0, 40) - 20)), WB_ALU, ME_NONE, EX_SLTI);
                3: issue(itype(6'h23, 0, rt, 16'(4 * $urandom_range(0, 7))), WB_MEM, ME_RD, EX_IMM);
                4: issue(itype(6'h2b, 0, rt, 16'(4 * $urandom_range(0, 7))), WB_NONE, ME_WR, EX_IMM);
                5: issue(itype(6'h04, rs, rt, 16'd0), WB_NONE, ME_BR, EX_SUB);
                default: idle(1);
            endcase
        end
        idle(4);
    endtask

    initial begin
        rst = 1'b1; instr = '0; instr_valid = 1'b0; WBID = '0; MEID = '0; EXID = '0;
        for (int i = 0; i < 256; i++) mmem[i] = 32'd0;
        mode = 1'b1;
        doReset();

        $display("[TB] forwarding: single addi");
        obsStalls = 0;
        issue(32'h20010005, WB_ALU, ME_NONE, EX_IMM);
        idle(4);
        checkOutput("t1_stall_cycles", obsStalls, 0);

        $display("[TB] forwarding: back-to-back dependent add");
        obsStalls = 0;
        issue(itype(6'h08, 0, 1, 16'd5), WB_ALU, ME_NONE, EX_IMM);
        issue(32'h00211020, WB_ALU, ME_NONE, EX_R);
        idle(4);
        checkOutput("t2_stall_cycles", obsStalls, 0);

        prelude();

        $display("[TB] forwarding: store/load and load-use");
        obsStalls = 0;
        issue(itype(6'h08, 0, 1, 16'd5), WB_ALU, ME_NONE, EX_IMM);
        issue(rtype(1, 1, 2, 6'h20), WB_ALU, ME_NONE, EX_R);
        issue(itype(6'h2b, 0, 2, 16'd8), WB_NONE, ME_WR, EX_IMM);
        issue(itype(6'h23, 0, 3, 16'd8), WB_MEM, ME_RD, EX_IMM);
        issue(rtype(3, 3, 4, 6'h20), WB_ALU, ME_NONE, EX_R);
        idle(4);
        checkOutput("t3_stall_cycles", obsStalls, 1);

        $display("[TB] forwarding: branch compare");
        issue(itype(6'h08, 0, 1, 16'd5), WB_ALU, ME_NONE, EX_IMM);
        issue(itype(6'h04, 1, 1, 16'd0), WB_NONE, ME_BR, EX_SUB);
        issue(itype(6'h04, 1, 0, 16'd0), WB_NONE, ME_BR, EX_SUB);
        idle(4);

        $display("[TB] reset with a store in MEM");
        issue(itype(6'h08, 0, 5, 16'd99), WB_ALU, ME_NONE, EX_IMM);
        idle(3);
        issue(itype(6'h2b, 0, 5, 16'd8), WB_NONE, ME_WR, EX_IMM);
        idle(1);
        doReset();
        idle(3);
        issue(itype(6'h23, 0, 3, 16'd8), WB_MEM, ME_RD, EX_IMM);
        idle(4);

        $display("[TB] forwarding: random program");
        randomProgram(220);

        mode = 1'b0;
        doReset();
        $display("[TB] no forwarding: dependent add");
        obsStalls = 0;
        issue(itype(6'h08, 0, 1, 16'd5), WB_ALU, ME_NONE, EX_IMM);
        issue(rtype(1, 1, 2, 6'h20), WB_ALU, ME_NONE, EX_R);
        idle(4);
        checkOutput("t4_stall_cycles", obsStalls, 2);

        prelude();
        $display("[TB] no forwarding: random program");
        randomProgram(220);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_datapath_fwd.md
Name: pipe_datapath_fwd

Overview:
Parametrised 4-stage (ID/EX/MEM/WB) MIPS-subset datapath with an internal register file and word-addressed data memory.
- Adds EX/MEM and MEM/WB operand forwarding, load-use hazard stall, and correct funct propagation through ID/EX.
- Sits between the instruction fetch/decode control unit, which supplies the instruction plus WB/ME/EX control groups, and the branch logic, which consumes zero_reg/branch_me.

Parameters:
- DATA_W, 32, datapath and memory word width (>=16).
- NREG, 32, register count (power of 2, <=32); register index = instr field bits [log2(NREG)-1:0].
- DMEM_DEPTH, 256, data memory words (power of 2).
- FWD_EN, 1, 1 = forwarding enabled; 0 = stall on every RAW hazard.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- instr  in  32  instruction in ID stage.
- instr_valid  in  1  instr/control groups valid this cycle.
- WBID  in  2  [1] RegWrite, [0] MemtoReg (1 = memory data).
- MEID  in  3  [2] Branch, [1] MemRead, [0] MemWrite.
- EXID  in  4  [3] RegDst (1 = Rd, 0 = Rt), [2:1] ALUOp, [0] ALUSrc (1 = sign-extended imm).
- stall  out  1  upstream must hold instr/controls this cycle.
- zero_reg  out  1  ALU zero flag of instruction in MEM.
- branch_me  out  1  Branch control of instruction in MEM.
- wb_valid  out  1  register write occurring this cycle.
- wb_addr  out  5  destination register of the write.
- wb_data  out  DATA_W  data written.

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous, active-high, on rst.
  - On rst, all pipeline registers become bubbles (all controls 0, valid 0).
  - Register file clears to 0. Data memory contents are unchanged.
  - All outputs read 0 in the cycle after rst is sampled high.
  - rst mid-operation discards all in-flight instructions; no register or memory write occurs on the reset edge.
- Register file: 2 read ports, 1 write port. Register 0 reads 0, and writes to it are ignored. Write-first bypass: an ID read of the register being written in WB returns the WB data.
- Stage flow:
  - Instruction accepted in ID in cycle N (instr_valid=1, stall=0) is in EX in N+1, MEM in N+2, WB in N+3.
  - wb_valid/wb_addr/wb_data are valid in cycle N+3; the register write occurs at the end of cycle N+3.
- ID/EX captures: Rs, Rt, Rd, funct (instr[5:0]), operands A/B, sign-extended imm[15:0] (to DATA_W), and the control groups.
- ALU:
  - ALUOp 00 = add; 01 = sub; 11 = slt.
  - ALUOp 10 decodes funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; any other funct = add.
  - Arithmetic is modulo 2^DATA_W. slt is signed.
  - zero = (result == 0).
- Destination register: RegDst ? Rd : Rt.
- Forwarding (FWD_EN=1), per EX operand:
  - If EX/MEM RegWrite and its dest != 0 and dest == src, select the EX/MEM ALU result.
  - Otherwise, if MEM/WB RegWrite and its dest != 0 and dest == src, select the MEM/WB write data.
  - Otherwise use the register value.
  - EX/MEM has priority over MEM/WB.
  - The forwarded B value feeds both the ALU (when ALUSrc=0) and store data.
- Load-use hazard:
  - Stall condition: ID/EX MemRead=1, ID/EX dest != 0, and dest equals ID Rs or Rt.
  - Response: stall=1 for one cycle. ID/EX loads a bubble. EX/MEM and MEM/WB advance normally.
- FWD_EN=0: stall=1 while any valid instruction in EX or MEM with RegWrite and nonzero dest matches ID Rs/Rt. The WB stage is covered by the write-first bypass.
- stall is combinational from current pipeline state.
- instr_valid=0 injects a bubble into ID/EX.
- Data memory:
  - Word address = ALU result[log2(DMEM_DEPTH)+1:2]; upper bits ignored, so addresses wrap.
  - Read is combinational in MEM. Write (MemWrite) occurs at the end of the MEM cycle.
  - A load immediately after a store to the same address returns the stored data.
- Simultaneous stall and rst: rst wins.

Test Plan:
- rst, then addi r1,r0,5 (0x20010005) with WBID=10, EXID=0001 in cycle 0 -> cycle 3: wb_valid=1, wb_addr=1, wb_data=5; stall never asserted.
- addi r1,r0,5 then add r2,r1,r1 (0x00211020; WBID=10, EXID=1100) back-to-back, FWD_EN=1 -> no stall; r2 wb_data=10 in cycle 4.
- addi r1,r0,5; add r2,r1,r1; sw r2,8(r0); lw r3,8(r0); add r4,r3,r3 -> stall=1 for exactly one cycle, the cycle the add sits in ID behind lw; wb r3=10, then r4=20.
- FWD_EN=0, addi r1,r0,5 then add r2,r1,r1 -> stall=1 for 2 cycles; r2 wb_data=10 in cycle 6.
- sub r0? no; r1=5, then beq-style sub with MEID=100, ALUOp=01, rs=rt=r1 -> in its MEM cycle branch_me=1, zero_reg=1. Repeat with rt=r0 -> zero_reg=0.
- rst asserted while sw r2,8(r0) is in MEM -> memory word 2 unchanged; outputs all 0 the next cycle; no wb_valid for 3 cycles.
